gp3_keys_pio: RTL and testbench
===============================

GP3_KEYS_PIO -- requirements
Module: gp3_keys_pio

Interface
REQ-001 The block SHALL take parameter WIDTH, default 5: number of input pins, 1..32.
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 4: stable cycles required before an input change is accepted; 0 bypasses debouncing.
REQ-003 The block SHALL take parameter EDGE_TYPE, default 1: edge captured (0 rising, 1 falling, 2 any).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port in_port, input, WIDTH bits: asynchronous key/switch inputs.
REQ-011 The block SHALL have port readdata, output, 32 bits: read data, zero-wait-state.
REQ-012 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 The block SHALL pass in_port through a two-flop synchronizer (s1, s2) per bit.
REQ-014 When DEBOUNCE_CYCLES > 0, each bit SHALL apply the following debounce rule to db and cnt:
- s2 == db: cnt <= 0.
- else if cnt == DEBOUNCE_CYCLES-1: db <= s2 and cnt <= 0.
- else: cnt <= cnt+1.
REQ-015 When DEBOUNCE_CYCLES == 0, db SHALL equal s2.
REQ-016 A clean in_port change SHALL be visible in db exactly 2+DEBOUNCE_CYCLES clock edges after it is sampled.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles at s2 SHALL NOT change db.
REQ-018 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, minimum 1.
REQ-019 The block SHALL register db_prev each cycle and detect edges on db vs db_prev per EDGE_TYPE.
REQ-020 A detected edge SHALL set the corresponding edgecapture bit on the next clock edge, i.e. 3+DEBOUNCE_CYCLES edges after the input change.
REQ-021 The register map SHALL be:
- addr 0: data, read-only, returns db zero-extended; writes ignored.
- addr 1: reserved, reads 0, writes ignored.
- addr 2: irqmask, read/write, writedata[WIDTH-1:0].
- addr 3: edgecapture, read; write-1-to-clear per bit.
REQ-022 A write SHALL occur only when chipselect=1 and write_n=0.
REQ-023 readdata SHALL be combinational from address and the current registers, with upper 32-WIDTH bits always 0, and SHALL NOT depend on chipselect.
REQ-024 When an edge event and a write-1-to-clear of the same edgecapture bit coincide in one cycle, the set SHALL win (bit = 1).
REQ-025 Clearing SHALL affect only bits written as 1; other bits, including newly set ones, SHALL be kept.
REQ-026 irq SHALL equal |(edgecapture & irqmask), a combinational function of registers, with no extra delay.
REQ-027 An edgecapture bit SHALL remain set while in_port keeps toggling (sticky) until it is cleared.

Reset
REQ-028 While reset_n=0 at a clock edge, s1, s2, db, db_prev, cnt, irqmask and edgecapture SHALL all be set to 0.
REQ-029 After reset, readdata SHALL be 0 on all addresses and irq SHALL be 0.
REQ-030 Reset asserted mid-debounce SHALL discard the pending change.
REQ-031 After reset deasserts with in_port held high, db SHALL rise after 2+DEBOUNCE_CYCLES edges, and the resulting db rise SHALL count as a rising edge.

Structure
REQ-032 Register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and EDGE_TYPE encodings SHALL reside in a shared package/include file.
REQ-033 The per-bit synchronizer plus debouncer SHALL be one sub-module, gp3_keys_debounce, instantiated WIDTH times via generate.

Verification (WIDTH=5, DEBOUNCE_CYCLES=4, EDGE_TYPE=1)
REQ-034 Scenario: reset with in_port=5'b11111, release reset -> data reads 5'h1F at edge 6, no edgecapture bit set, irq=0.
REQ-035 Scenario: drive in_port[0] low and hold it -> data reads 5'h1E at edge 6, edgecapture reads 5'h01 at edge 7; with irqmask=5'h01, irq goes to 1 on that same edge.
REQ-036 Scenario: pulse in_port[2] low for 3 cycles -> data remains 5'h1F, edgecapture remains 0.
REQ-037 Scenario: edgecapture=5'h03, write 5'h01 to addr 3 -> edgecapture reads 5'h02, and irq follows irqmask.
REQ-038 Scenario: write-1-to-clear bit 1 on the same cycle that a new bit-1 edge is captured -> bit 1 stays 1.
REQ-039 Scenario: write 5'h1F to addr 0 and addr 1, and write with chipselect=0 to addr 2 -> no register changes; addr 1 reads 0.

Source files
------------

// File: rtl/gp3_keys_pio_pkg.sv
// Shared constants for the gp3 keys PIO block.
// Register map, edge-type encodings and counter sizing.
package gp3_keys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Debounce counter width, never below one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gp3_keys_debounce.sv
// One key input: two-flop synchronizer followed by a
// stable-count debouncer (bypassed when DEBOUNCE_CYCLES is 0).
module gp3_keys_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_db
);
  import gp3_keys_pio_pkg::*;

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_db = r_s2;
    end else begin : g_db
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST =
        CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_db;

      // Any return to the accepted level restarts the count.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_db = r_db;
    end
  endgenerate

endmodule

// File: rtl/gp3_keys_pio.sv
// Debounced key PIO with Avalon-MM slave, sticky edge
// capture (write-1-to-clear) and masked level interrupt.
module gp3_keys_pio #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  import gp3_keys_pio_pkg::*;

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wd;
  logic             w_wr;
  logic [WIDTH-1:0] r_db_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
      gp3_keys_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .i_pin  (in_port[gi]),
        .o_db   (w_db[gi])
      );
    end
    if (WIDTH < 32) begin : g_pad
      logic w_unused_wd;
      assign w_unused_wd = |writedata[31:WIDTH];
    end
  endgenerate

  assign w_wd = writedata[WIDTH-1:0];
  assign w_wr = chipselect & ~write_n;

  always_comb begin
    w_edge = '0;
    if (EDGE_TYPE == EDGE_RISE) begin
      w_edge = w_db & ~r_db_prev;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      w_edge = ~w_db & r_db_prev;
    end else begin
      w_edge = w_db ^ r_db_prev;
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_wr && (address == ADDR_EDGECAP)) begin
      w_clr = w_wd;
    end
  end

  // A new edge overrides a same-cycle clear of that bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_db_prev <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_db_prev <= w_db;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= w_wd;
      end
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:    readdata = 32'(w_db);
      ADDR_RSVD:    readdata = '0;
      ADDR_IRQMASK: readdata = 32'(r_irqmask);
      ADDR_EDGECAP: readdata = 32'(r_edgecap);
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_gp3_keys_pio.sv
// Bench for gp3_keys_pio: windowed debounce model checked
// every cycle, plus directed literal register checks.
module tb_gp3_keys_pio;

  localparam int W  = 5;
  localparam int D  = 4;
  localparam int ET = 1;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks;
  int failures;

  gp3_keys_pio #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .EDGE_TYPE      (ET)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Model: db flips once the last D synchronized samples
  // all disagree with it; edges are latched one edge later.
  logic [W-1:0] m_s1, m_s2, m_db, m_dbp, m_mask, m_ec;
  logic [W-1:0] hist[$];
  logic [W-1:0] ev, clr, nd;
  logic         flip;
  bit           m_ready;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_dbp = '0; m_mask = '0; m_ec = '0;
      hist.delete();
      m_ready = 1'b1;
    end else begin
      if (ET == 0) ev = m_db & ~m_dbp;
      else if (ET == 1) ev = ~m_db & m_dbp;
      else ev = m_db ^ m_dbp;
      clr = '0;
      if (chipselect && !write_n) begin
        if (address == 2'd3) clr = writedata[W-1:0];
        if (address == 2'd2) m_mask = writedata[W-1:0];
      end
      m_ec = (m_ec & ~clr) | ev;
      m_dbp = m_db;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      nd = m_db;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          flip = 1'b1;
          for (int i = 0; i < D; i++)
            if (hist[i][b] == m_db[b]) flip = 1'b0;
          if (flip) nd[b] = ~m_db[b];
        end
      end
      m_db = nd;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  logic [31:0] m_rd;
  always @(posedge clk) begin
    #1;
    if (m_ready) begin
      case (address)
        2'd0: m_rd = 32'(m_db);
        2'd2: m_rd = 32'(m_mask);
        2'd3: m_rd = 32'(m_ec);
        default: m_rd = '0;
      endcase
      check("model_rdata", readdata, m_rd);
      check("model_irq", {31'd0, irq},
            {31'd0, |(m_ec & m_mask)});
    end
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [31:0] exp,
                    input string nm);
    address = a;
    #1;
    check(nm, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    edge_n(1);
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_ready = 1'b0;
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    in_port = 5'h1F;

    // reset state
    edge_n(2);
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_ecap");
    check("rst_irq", {31'd0, irq}, 32'd0);
    edge_n(1);
    reset_n = 1'b1;

    // keys high out of reset: rise at edge 6, not captured
    edge_n(5);
    rd(2'd0, 32'h00, "rel_data_e5");
    edge_n(1);
    rd(2'd0, 32'h1F, "rel_data_e6");
    edge_n(1);
    rd(2'd3, 32'h00, "rel_ecap_e7");
    check("rel_irq", {31'd0, irq}, 32'd0);

    // bit 0 falls: data at edge 6, capture+irq at edge 7
    wr(2'd2, 32'h01);
    in_port = 5'h1E;
    edge_n(5);
    rd(2'd0, 32'h1F, "fall_data_e5");
    edge_n(1);
    rd(2'd0, 32'h1E, "fall_data_e6");
    rd(2'd3, 32'h00, "fall_ecap_e6");
    check("fall_irq_e6", {31'd0, irq}, 32'd0);
    edge_n(1);
    rd(2'd3, 32'h01, "fall_ecap_e7");
    check("fall_irq_e7", {31'd0, irq}, 32'd1);

    // 3-cycle glitch on bit 2 is filtered
    in_port = 5'h1A;
    edge_n(3);
    in_port = 5'h1E;
    edge_n(10);
    rd(2'd0, 32'h1E, "glitch_data");
    rd(2'd3, 32'h01, "glitch_ecap");

    // partial write-1-to-clear
    in_port = 5'h1C;
    edge_n(7);
    rd(2'd3, 32'h03, "w1c_pre");
    check("w1c_irq_pre", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h01);
    rd(2'd3, 32'h02, "w1c_post");
    check("w1c_irq_post", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h02);
    check("w1c_irq_mask2", {31'd0, irq}, 32'd1);

    // clear of bit 1 coincides with new bit-1 capture
    in_port = 5'h1E;
    edge_n(8);
    rd(2'd0, 32'h1E, "coll_data_hi");
    rd(2'd3, 32'h02, "coll_sticky");
    in_port = 5'h1C;
    edge_n(6);
    wr(2'd3, 32'h02);
    rd(2'd3, 32'h02, "coll_set_wins");
    wr(2'd3, 32'h02);
    rd(2'd3, 32'h00, "coll_cleared");
    check("coll_irq", {31'd0, irq}, 32'd0);

    // ignored writes
    wr(2'd0, 32'h1F);
    wr(2'd1, 32'h1F);
    address = 2'd2;
    writedata = 32'h1F;
    write_n = 1'b0;
    chipselect = 1'b0;
    edge_n(1);
    write_n = 1'b1;
    writedata = '0;
    rd(2'd1, 32'h00, "ign_rsvd");
    rd(2'd2, 32'h02, "ign_mask");
    rd(2'd0, 32'h1C, "ign_data");
    rd(2'd3, 32'h00, "ign_ecap");

    // exactly D-cycle pulse on bit 3 is accepted
    in_port = 5'h14;
    edge_n(4);
    in_port = 5'h1C;
    edge_n(12);
    rd(2'd0, 32'h1C, "pulseD_data");
    rd(2'd3, 32'h08, "pulseD_ecap");

    // reset mid-debounce discards pending rise
    in_port = 5'h1F;
    edge_n(3);
    reset_n = 1'b0;
    edge_n(1);
    rd(2'd0, 32'h00, "mid_rst_data");
    rd(2'd3, 32'h00, "mid_rst_ecap");
    rd(2'd2, 32'h00, "mid_rst_mask");
    reset_n = 1'b1;
    edge_n(5);
    rd(2'd0, 32'h00, "mid_rel_e5");
    edge_n(1);
    rd(2'd0, 32'h1F, "mid_rel_e6");
    edge_n(2);
    rd(2'd3, 32'h00, "mid_rel_ecap");

    edge_n(2);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
